haz_detect: RTL and testbench
=============================

Name: haz_detect

Overview:
- Upstream hazard-detection stage feeding the hazard-resolution FSM.
- Tracks in-flight instructions in a shadow EX/MEM/WB scoreboard.
- Compares the decoding (ID) instruction against that scoreboard and produces the FSM's hazard inputs: data, str, ctrl, branch, fwrd, crct.
- Also drives forwarding-mux selects to the datapath and keeps stall/flush statistics counters.

Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 8, statistics counter width
- SHARED_MEM, 1, 1 = single unified memory port, so a load/store in MEM blocks fetch

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_W  source 1
- id_rs2  in  REG_W  source 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  REG_W  destination
- id_wr_en  in  1  instruction writes rd
- id_is_load  in  1  load instruction
- id_is_mem  in  1  load or store
- id_is_branch  in  1  conditional branch
- id_pred_taken  in  1  predictor outcome for the ID branch
- ex_br_taken  in  1  actual branch outcome from ALU (valid when EX holds a branch)
- pc_freeze  in  1  from FSM; ID held
- do_flush  in  1  from FSM; kill wrong path
- data  out  1  ID source matches a pending write
- fwrd  out  1  every matching hazard is forwardable
- str  out  1  structural memory-port conflict
- ctrl  out  1  branch in ID or unresolved in EX
- branch  out  1  branch resolving this cycle
- crct  out  1  prediction correct (meaningful only when branch=1)
- fwd_sel_rs1  out  2  forwarding select: 00 regfile, 01 EX, 10 MEM, 11 WB
- fwd_sel_rs2  out  2  same encoding for rs2
- stall_cnt  out  CNT_W  cycles with pc_freeze=1, saturating
- flush_cnt  out  CNT_W  do_flush assertions, saturating

Behaviour:
- Shadow entry per stage (EX, MEM, WB): {v, rd, wr_en, is_load, is_mem, is_branch, pred}.
- Reset (async, rst_n=0): all v=0, both counters 0. With all v=0, every output is 0 except ctrl, which follows id_valid&&id_is_branch.
- Each clock edge:
  - MEM<=EX, WB<=MEM, unconditionally.
  - EX<=ID fields with v=id_valid, when pc_freeze=0 and do_flush=0.
  - Otherwise EX<=bubble (v=0).
- do_flush has priority over pc_freeze. Flush also forces the ID contribution to all outputs to 0 in that cycle.
- A stage "matches" a source when: v && wr_en && rd!=0 && rd==rs && use_rs && id_valid.
- Outputs are combinational from the ID inputs plus the registered shadow. They add zero latency so the FSM sees them in the same cycle.
- data = any match in EX or MEM, on either source. A WB match is covered by write-through and is not a hazard.
- fwrd = data && no EX match with EX.is_load, i.e. a load-use is not forwardable.
- fwd_sel per source: youngest match wins, priority EX>MEM>WB. An EX load match yields 00 (stall instead).
- str = SHARED_MEM && MEM.v && MEM.is_mem.
- ctrl = (id_valid && id_is_branch) || (EX.v && EX.is_branch).
- branch = EX.v && EX.is_branch.
- crct = branch && (ex_br_taken == EX.pred).
- Register 0 never creates a hazard. Simultaneous EX and MEM matches on the same register are resolved by EX priority.
- Counters saturate at all-ones; no wrap.
- Reset mid-operation clears the shadow immediately (asynchronously); outputs reflect the empty pipeline in the same cycle.

Decomposition:
- Shared package:
  - fwd-select encoding constants (FWD_RF, FWD_EX, FWD_MEM, FWD_WB)
  - shadow-entry struct/field widths
  - REG_W default
- Sub-module haz_match: pure combinational compare of one source vs three shadow entries. Returns match flags and fwd_sel. Instantiated twice (rs1, rs2).

Test Plan:
- Reset with rst_n=0 mid-stream while EX holds a load -> all shadow v=0 and data/fwrd/branch/str=0 immediately; counters=0.
- ADD r3 then dependent SUB reads r3 (EX match, non-load) -> data=1, fwrd=1, fwd_sel_rs1=01.
- LW r5 then ADD reads r5 -> data=1, fwrd=0, fwd_sel_rs1=00. Drive pc_freeze=1 one cycle -> EX bubble. Next cycle r5 is in MEM -> data=1, fwrd=1, fwd_sel_rs1=10; stall_cnt=1.
- Instruction writing r0 followed by a reader of r0 -> data=0, fwd_sel=00.
- Branch with pred_taken=1 reaches EX, ex_br_taken=0 -> branch=1, crct=0. Assert do_flush -> EX bubble next cycle, flush_cnt increments. Same sequence with ex_br_taken=1 -> crct=1.
- SW in MEM with SHARED_MEM=1 -> str=1. Drive pc_freeze=1 for 300 cycles -> stall_cnt saturates at 255.

Source files
------------

// File: rtl/haz_detect_pkg.sv
// Shared definitions for the hazard-detection stage: forwarding encodings,
// shadow-pipeline stage indices and the per-entry attribute record.
package haz_detect_pkg;

    localparam int unsigned DEF_REG_W = 5;
    localparam int unsigned NUM_STG   = 3;

    localparam int unsigned STG_EX  = 0;
    localparam int unsigned STG_MEM = 1;
    localparam int unsigned STG_WB  = 2;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // Width-independent part of a shadow entry; v and rd live alongside it.
    typedef struct packed {
        logic wr_en;
        logic is_load;
        logic is_mem;
        logic is_branch;
        logic pred;
    } shadow_attr_t;

endpackage

// File: rtl/haz_match.sv
// Compares one ID source register against the EX/MEM/WB shadow entries and
// picks the forwarding source, youngest match first.
module haz_match
    import haz_detect_pkg::*;
#(
    parameter int unsigned REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0]         rs,
    input  logic                     use_rs,
    input  logic                     id_valid,
    input  logic [NUM_STG-1:0]       stg_v,
    input  logic [NUM_STG-1:0]       stg_wr_en,
    input  logic [NUM_STG*REG_W-1:0] stg_rd,
    input  logic                     ex_is_load,
    output logic [NUM_STG-1:0]       match,
    output logic [1:0]               fwd_sel
);

    always_comb begin
        for (int unsigned i = 0; i < NUM_STG; i++) begin
            match[i] = stg_v[i] && stg_wr_en[i] && use_rs && id_valid &&
                       (rs != '0) && (stg_rd[i*REG_W +: REG_W] == rs);
        end

        fwd_sel = FWD_RF;
        if (match[STG_EX]) begin
            // A load in EX has no data yet; the FSM stalls instead.
            fwd_sel = ex_is_load ? FWD_RF : FWD_EX;
        end else if (match[STG_MEM]) begin
            fwd_sel = FWD_MEM;
        end else if (match[STG_WB]) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/haz_detect.sv
// Hazard detection: shadow EX/MEM/WB scoreboard, same-cycle hazard flags for
// the resolution FSM, forwarding selects and saturating stall/flush counters.
module haz_detect
    import haz_detect_pkg::*;
#(
    parameter int unsigned REG_W      = DEF_REG_W,
    parameter int unsigned CNT_W      = 8,
    parameter bit          SHARED_MEM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             id_is_mem,
    input  logic             id_is_branch,
    input  logic             id_pred_taken,
    input  logic             ex_br_taken,
    input  logic             pc_freeze,
    input  logic             do_flush,
    output logic             data,
    output logic             fwrd,
    output logic             str,
    output logic             ctrl,
    output logic             branch,
    output logic             crct,
    output logic [1:0]       fwd_sel_rs1,
    output logic [1:0]       fwd_sel_rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic         v;
        logic [REG_W-1:0] rd;
        shadow_attr_t attr;
    } entry_t;

    entry_t ex_q, mem_q, wb_q, id_entry;
    logic   id_live;
    logic [NUM_STG-1:0] m1, m2;

    // A flushed ID instruction is wrong-path and must not raise anything.
    assign id_live = id_valid && !do_flush;

    always_comb begin
        id_entry                = '0;
        id_entry.v              = id_valid;
        id_entry.rd             = id_rd;
        id_entry.attr.wr_en     = id_wr_en;
        id_entry.attr.is_load   = id_is_load;
        id_entry.attr.is_mem    = id_is_mem;
        id_entry.attr.is_branch = id_is_branch;
        id_entry.attr.pred      = id_pred_taken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            ex_q  <= (!pc_freeze && !do_flush) ? id_entry : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_freeze && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (do_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    haz_match #(.REG_W(REG_W)) u_match_rs1 (
        .rs         (id_rs1),
        .use_rs     (id_use_rs1),
        .id_valid   (id_live),
        .stg_v      ({wb_q.v, mem_q.v, ex_q.v}),
        .stg_wr_en  ({wb_q.attr.wr_en, mem_q.attr.wr_en, ex_q.attr.wr_en}),
        .stg_rd     ({wb_q.rd, mem_q.rd, ex_q.rd}),
        .ex_is_load (ex_q.attr.is_load),
        .match      (m1),
        .fwd_sel    (fwd_sel_rs1)
    );

    haz_match #(.REG_W(REG_W)) u_match_rs2 (
        .rs         (id_rs2),
        .use_rs     (id_use_rs2),
        .id_valid   (id_live),
        .stg_v      ({wb_q.v, mem_q.v, ex_q.v}),
        .stg_wr_en  ({wb_q.attr.wr_en, mem_q.attr.wr_en, ex_q.attr.wr_en}),
        .stg_rd     ({wb_q.rd, mem_q.rd, ex_q.rd}),
        .ex_is_load (ex_q.attr.is_load),
        .match      (m2),
        .fwd_sel    (fwd_sel_rs2)
    );

    // WB matches are absorbed by regfile write-through.
    assign data   = m1[STG_EX] || m1[STG_MEM] || m2[STG_EX] || m2[STG_MEM];
    assign fwrd   = data && !(ex_q.attr.is_load && (m1[STG_EX] || m2[STG_EX]));
    assign str    = SHARED_MEM && mem_q.v && mem_q.attr.is_mem;
    assign branch = ex_q.v && ex_q.attr.is_branch;
    assign ctrl   = (id_live && id_is_branch) || branch;
    assign crct   = branch && (ex_br_taken == ex_q.attr.pred);

    logic unused_fields;
    assign unused_fields = ^{wb_q.attr.is_load, wb_q.attr.is_mem, wb_q.attr.is_branch,
                             wb_q.attr.pred, m1[STG_WB], m2[STG_WB]};

endmodule

// File: tb/tb_haz_detect.sv
// Directed bench for haz_detect: a cycle-by-cycle instruction stream with
// hand-computed outputs, then reset-mid-stream and counter saturation.
module tb_haz_detect;

    logic       clk, rst_n;
    logic       id_valid, id_use_rs1, id_use_rs2, id_wr_en, id_is_load, id_is_mem;
    logic       id_is_branch, id_pred_taken, ex_br_taken, pc_freeze, do_flush;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       data, fwrd, str, ctrl, branch, crct;
    logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic [7:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    haz_detect dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_rd         (id_rd),
        .id_wr_en      (id_wr_en),
        .id_is_load    (id_is_load),
        .id_is_mem     (id_is_mem),
        .id_is_branch  (id_is_branch),
        .id_pred_taken (id_pred_taken),
        .ex_br_taken   (ex_br_taken),
        .pc_freeze     (pc_freeze),
        .do_flush      (do_flush),
        .data          (data),
        .fwrd          (fwrd),
        .str           (str),
        .ctrl          (ctrl),
        .branch        (branch),
        .crct          (crct),
        .fwd_sel_rs1   (fwd_sel_rs1),
        .fwd_sel_rs2   (fwd_sel_rs2),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       mem;
        logic       br;
        logic       pred;
    } in_t;

    typedef struct packed {
        logic       data;
        logic       fwrd;
        logic       str;
        logic       ctrl;
        logic       branch;
        logic       crct;
        logic [1:0] s1;
        logic [1:0] s2;
    } out_t;

    typedef struct packed {
        in_t  in;
        logic taken;
        logic frz;
        logic fl;
        out_t e;
    } vec_t;

    vec_t vq[$];

    function automatic in_t id(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                               logic [4:0] rd, logic wr, logic ld, logic mem, logic br,
                               logic pred);
        in_t r;
        r = '{v, rs1, u1, rs2, u2, rd, wr, ld, mem, br, pred};
        return r;
    endfunction

    function automatic out_t ex(logic d, logic f, logic s, logic c, logic b, logic k,
                                logic [1:0] s1, logic [1:0] s2);
        out_t r;
        r = '{d, f, s, c, b, k, s1, s2};
        return r;
    endfunction

    function automatic vec_t row(in_t i, logic t, logic fz, logic fl, out_t e);
        vec_t r;
        r = '{i, t, fz, fl, e};
        return r;
    endfunction

    task automatic chk(input string nm, input int r, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, r, act, exp);
        end
    endtask

    task automatic drive(input in_t i, input logic t, input logic fz, input logic fl);
        id_valid      = i.valid;
        id_rs1        = i.rs1;
        id_use_rs1    = i.use1;
        id_rs2        = i.rs2;
        id_use_rs2    = i.use2;
        id_rd         = i.rd;
        id_wr_en      = i.wr;
        id_is_load    = i.ld;
        id_is_mem     = i.mem;
        id_is_branch  = i.br;
        id_pred_taken = i.pred;
        ex_br_taken   = t;
        pc_freeze     = fz;
        do_flush      = fl;
    endtask

    task automatic check_out(input int r, input out_t e);
        chk("data", r, 32'(data), 32'(e.data));
        chk("fwrd", r, 32'(fwrd), 32'(e.fwrd));
        chk("str", r, 32'(str), 32'(e.str));
        chk("ctrl", r, 32'(ctrl), 32'(e.ctrl));
        chk("branch", r, 32'(branch), 32'(e.branch));
        chk("crct", r, 32'(crct), 32'(e.crct));
        chk("fwd_sel_rs1", r, 32'(fwd_sel_rs1), 32'(e.s1));
        chk("fwd_sel_rs2", r, 32'(fwd_sel_rs2), 32'(e.s2));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stream; comment shows shadow (EX/MEM/WB) seen by that row.
        vq.push_back(row(id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
        vq.push_back(row(id(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0), 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 1, 0)));
        vq.push_back(row(id(1, 3, 1, 4, 1, 5, 1, 0, 0, 0, 0), 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 2, 1)));
        vq.push_back(row(id(1, 3, 1, 0, 1, 6, 1, 0, 0, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3, 0)));
        vq.push_back(row(id(1, 0, 1, 0, 0, 5, 1, 1, 1, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
        // 5: LW r5 in EX -> load-use, freeze one cycle
        vq.push_back(row(id(1, 5, 1, 6, 1, 7, 1, 0, 0, 0, 0), 0, 1, 0, ex(1, 0, 0, 0, 0, 0, 0, 2)));
        vq.push_back(row(id(1, 5, 1, 6, 1, 7, 1, 0, 0, 0, 0), 0, 0, 0, ex(1, 1, 1, 0, 0, 0, 2, 3)));
        // 7-8: writer of r0, then reader of r0
        vq.push_back(row(id(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
        vq.push_back(row(id(1, 0, 1, 0, 1, 8, 1, 0, 0, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
        // 9-11: branch pred=1, actual 0, flushed
        vq.push_back(row(id(1, 8, 1, 7, 1, 0, 0, 0, 0, 1, 1), 0, 0, 0, ex(1, 1, 0, 1, 0, 0, 1, 3)));
        vq.push_back(row(id(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0), 0, 0, 1, ex(0, 0, 0, 1, 1, 0, 0, 0)));
        vq.push_back(row(id(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3, 0)));
        // 12-13: branch pred=1, actual 1
        vq.push_back(row(id(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1), 0, 0, 0, ex(1, 1, 0, 1, 0, 0, 1, 0)));
        vq.push_back(row(id(0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, ex(0, 0, 0, 1, 1, 1, 0, 0)));
        // 14-16: SW travels to MEM
        vq.push_back(row(id(1, 1, 1, 9, 1, 0, 0, 0, 1, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 3)));
        vq.push_back(row(id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
        vq.push_back(row(id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, ex(0, 0, 1, 0, 0, 0, 0, 0)));
        // 17-18: flush beats freeze, r10 never enters EX
        vq.push_back(row(id(1, 1, 1, 2, 1, 10, 1, 0, 0, 0, 0), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0, 0)));
        vq.push_back(row(id(1, 10, 1, 10, 1, 11, 1, 0, 0, 0, 0), 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
        // 19-20: r11 in EX and MEM at once; unused rs1 ignored
        vq.push_back(row(id(1, 11, 1, 0, 0, 11, 1, 0, 0, 0, 0), 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 1, 0)));
        vq.push_back(row(id(1, 11, 0, 11, 1, 12, 1, 0, 0, 0, 0), 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 1)));

        // Reset with a branch in ID: only ctrl may be high.
        rst_n = 1'b0;
        drive(id(1, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0), 1'b0, 1'b0, 1'b0);
        tick;
        tick;
        check_out(-1, ex(0, 0, 0, 1, 0, 0, 0, 0));
        chk("stall_cnt_rst", -1, 32'(stall_cnt), 32'd0);
        chk("flush_cnt_rst", -1, 32'(flush_cnt), 32'd0);
        drive(id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].in, vq[i].taken, vq[i].frz, vq[i].fl);
            #1;
            check_out(i, vq[i].e);
            tick;
        end
        chk("stall_cnt_stream", 99, 32'(stall_cnt), 32'd2);
        chk("flush_cnt_stream", 99, 32'(flush_cnt), 32'd2);

        // LW r12 into EX, then async reset while a dependent sits in ID.
        drive(id(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 0), 1'b0, 1'b0, 1'b0);
        tick;
        drive(id(1, 12, 1, 0, 0, 13, 1, 0, 0, 1, 0), 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_data", 100, 32'(data), 32'd1);
        chk("pre_rst_fwrd", 100, 32'(fwrd), 32'd0);
        rst_n = 1'b0;
        #1;
        check_out(101, ex(0, 0, 0, 1, 0, 0, 0, 0));
        chk("stall_cnt_midrst", 101, 32'(stall_cnt), 32'd0);
        chk("flush_cnt_midrst", 101, 32'(flush_cnt), 32'd0);
        drive(id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Saturation of the stall counter.
        pc_freeze = 1'b1;
        for (int i = 0; i < 300; i++) tick;
        chk("stall_cnt_sat", 102, 32'(stall_cnt), 32'd255);
        pc_freeze = 1'b0;
        tick;
        chk("stall_cnt_hold", 103, 32'(stall_cnt), 32'd255);
        chk("flush_cnt_idle", 103, 32'(flush_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
